// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the decryptor.
// Holds the round count, the key-schedule round constants, the forward and
// inverse S-box tables with lookup helpers, the GF(2^8) arithmetic helpers
// and the controller state type.
package aes_pkg;

  localparam logic [3:0] NR     = 4'd10;  // AES-128 round count
  localparam int         NUM_RK = 11;     // round keys rk[0]..rk[NR]

  // Index n holds Rcon[n]. Entry 0 is never used by the key schedule.
  localparam logic [0:10][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {IDLE, KEYEXP, INIT, ROUND} state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11b).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant b only the set bits cost logic.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round, purely combinational.
// Ports:
//   state_i  128  round input state (byte 0 in [127:120], column-major)
//   rkey_i   128  round key to add
//   last_i   1    final round: skip InvMixColumns
//   state_o  128  InvMixColumns(InvSubBytes(InvShiftRows(state_i)) ^ rkey_i),
//                 or the same without InvMixColumns when last_i = 1
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rkey_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  logic [127:0] ark;
  logic [127:0] mix;

  // Byte gi sits at row gi%4, column gi/4. InvShiftRows rotates row r right
  // by r, so output (r, c) takes input (r, (c - r) mod 4).
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
    assign ark[127-8*gi -: 8] = inv_sbox(state_i[127-8*SRC -: 8]) ^ rkey_i[127-8*gi -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] s0, s1, s2, s3;
    assign s0 = ark[127-32*gi -: 8];
    assign s1 = ark[119-32*gi -: 8];
    assign s2 = ark[111-32*gi -: 8];
    assign s3 = ark[103-32*gi -: 8];
    assign mix[127-32*gi -: 32] = {
      gf_mul(s0, 8'h0e) ^ gf_mul(s1, 8'h0b) ^ gf_mul(s2, 8'h0d) ^ gf_mul(s3, 8'h09),
      gf_mul(s0, 8'h09) ^ gf_mul(s1, 8'h0e) ^ gf_mul(s2, 8'h0b) ^ gf_mul(s3, 8'h0d),
      gf_mul(s0, 8'h0d) ^ gf_mul(s1, 8'h09) ^ gf_mul(s2, 8'h0e) ^ gf_mul(s3, 8'h0b),
      gf_mul(s0, 8'h0b) ^ gf_mul(s1, 8'h0d) ^ gf_mul(s2, 8'h09) ^ gf_mul(s3, 8'h0e)
    };
  end

  assign state_o = last_i ? ark : mix;

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-128 decryptor: 10 key-schedule cycles, one initial
// AddRoundKey cycle, then 10 inverse rounds through a single shared
// aes_inv_round instance. done rises 21 cycles after the accepted start.
// Ports:
//   clk     1    clock, rising edge
//   reset   1    synchronous active-high reset
//   start   1    request, sampled only while busy = 0
//   Block   128  ciphertext, captured on the accepted start edge
//   Key     128  cipher key, captured on the accepted start edge
//   busy    1    operation in flight
//   done    1    one-cycle completion pulse
//   Result  128  plaintext, held until the next completion
module aes_decrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] Block,
  input  logic [127:0] Key,
  output logic         busy,
  output logic         done,
  output logic [127:0] Result
);

  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;        // key-schedule step, then round index
  logic [127:0] blk_q, blk_d;
  logic [127:0] st_q, st_d;
  logic [127:0] res_q, res_d;
  logic         done_q, done_d;
  logic [127:0] rk_q [NUM_RK];

  logic         rk_we;
  logic [3:0]   rk_wa;
  logic [127:0] rk_wd;

  // Key expansion: rk[rnd] is derived from rk[rnd-1].
  logic [3:0]   prev_idx;
  logic [127:0] prev_rk;
  logic [31:0]  w3, temp, n0, n1, n2, n3;
  logic [127:0] key_next;

  assign prev_idx = (rnd_q != 4'd0) ? rnd_q - 4'd1 : 4'd0;
  assign prev_rk  = rk_q[prev_idx];
  assign w3       = prev_rk[31:0];
  // RotWord then SubWord, then Rcon into the leading byte.
  assign temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
              ^ {RCON[rnd_q], 24'h000000};
  assign n0 = prev_rk[127:96] ^ temp;
  assign n1 = prev_rk[95:64]  ^ n0;
  assign n2 = prev_rk[63:32]  ^ n1;
  assign n3 = prev_rk[31:0]   ^ n2;
  assign key_next = {n0, n1, n2, n3};

  logic [127:0] round_key;
  logic         last_round;
  logic [127:0] round_out;

  assign round_key  = rk_q[rnd_q];
  assign last_round = (rnd_q == 4'd0);

  aes_inv_round u_inv_round (
    .state_i (st_q),
    .rkey_i  (round_key),
    .last_i  (last_round),
    .state_o (round_out)
  );

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    blk_d   = blk_q;
    st_d    = st_q;
    res_d   = res_q;
    done_d  = 1'b0;
    rk_we   = 1'b0;
    rk_wa   = rnd_q;
    rk_wd   = key_next;
    case (state_q)
      IDLE: begin
        if (start) begin
          blk_d   = Block;
          rk_we   = 1'b1;
          rk_wa   = 4'd0;
          rk_wd   = Key;
          rnd_d   = 4'd1;
          state_d = KEYEXP;
        end
      end
      KEYEXP: begin
        rk_we = 1'b1;
        if (rnd_q == NR) state_d = INIT;
        else             rnd_d   = rnd_q + 4'd1;
      end
      INIT: begin
        st_d    = blk_q ^ rk_q[NR];
        rnd_d   = NR - 4'd1;
        state_d = ROUND;
      end
      ROUND: begin
        if (rnd_q == 4'd0) begin
          res_d   = round_out;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          st_d  = round_out;
          rnd_d = rnd_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      blk_q   <= '0;
      st_q    <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_RK; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      st_q    <= st_d;
      res_q   <= res_d;
      done_q  <= done_d;
      if (rk_we) rk_q[rk_wa] <= rk_wd;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign Result = res_q;

endmodule

// File: tb/tb_aes_decrypt.sv
// Self-checking bench for aes_decrypt: FIPS-197 vector table, hand-written
// control-timing sequences, and random blocks checked against an AES-128
// encryption model (decrypt(encrypt(p)) must return p).
module tb_aes_decrypt;

  logic         clk, reset, start, busy, done;
  logic [127:0] Block, Key, Result;

  int n_checks = 0;
  int n_fail   = 0;

  aes_decrypt dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .Block  (Block),
    .Key    (Key),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Z_PT   = 128'h140f0f1011b5223d79587717ffd9ec3a;

  typedef struct {
    logic [127:0] key;
    logic [127:0] blk;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [3];

  // ---------------- reference model (AES-128 encryption) ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: field inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0]  inv, s;
    logic [15:0] t;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      if (v != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
      end
      s = inv ^ 8'h63;
      for (int n = 1; n <= 4; n++) begin
        t = {inv, inv} << n;
        s = s ^ t[15:8];
      end
      sb[v] = s;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      // SubBytes + ShiftRows: output (row, col) takes input (row, col + row).
      for (int j = 0; j < 16; j++) t[j] = sb[s[4*(((j/4) + (j%4)) % 4) + (j%4)]];
      for (int c = 0; c < 4; c++) begin
        if (r != 10) begin
          s[4*c+0] = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end else begin
          for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) out[127-8*j -: 8] = s[j];
    return out;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Starts one operation from a point just after a clock edge with the DUT
  // idle (or in its done cycle). Returns with the DUT in its done cycle and
  // lat = edges from the start-sampling edge to done (0 if it never came).
  task automatic run_op(input logic [127:0] key, input logic [127:0] blk,
                        input bit hold_start, input bit scramble, output int lat);
    Key = key; Block = blk; start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    check_bit("busy_after_start", busy, 1'b1);
    check_bit("done_low_after_start", done, 1'b0);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (scramble) begin
        Block = {$urandom, $urandom, $urandom, $urandom};
        Key   = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat != 0) check_bit("busy_low_in_done_cycle", busy, 1'b0);
    $display("op key=%h block=%h result=%h latency=%0d", key, blk, Result, lat);
  endtask

  logic [127:0] rk, rp, rc_t;
  int lat, ndone, nbusy;

  initial begin
    reset = 1'b1; start = 1'b0; Block = '0; Key = '0;
    build_sbox();
    vecs[0] = '{key: C1_KEY,  blk: C1_CT,  exp: C1_PT};
    vecs[1] = '{key: B_KEY,   blk: B_CT,   exp: B_PT};
    vecs[2] = '{key: 128'h0,  blk: 128'h0, exp: Z_PT};

    repeat (3) @(posedge clk);
    #1;
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check("reset_result", Result, 128'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_bit("idle_no_start_busy", busy, 1'b0);

    // Vector table
    for (int i = 0; i < 3; i++) begin
      run_op(vecs[i].key, vecs[i].blk, 1'b0, 1'b0, lat);
      check_int($sformatf("vec%0d_latency", i), lat, 21);
      check($sformatf("vec%0d_result", i), Result, vecs[i].exp);
      @(posedge clk); #1;
      check_bit($sformatf("vec%0d_done_fall", i), done, 1'b0);
    end
    repeat (5) @(posedge clk);
    #1;
    check("zero_result_stable", Result, Z_PT);

    // start held high through busy with Block/Key changing every cycle
    run_op(C1_KEY, C1_CT, 1'b1, 1'b1, lat);
    start = 1'b0;
    check_int("hold_latency", lat, 21);
    check("hold_result", Result, C1_PT);
    ndone = 0; nbusy = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (busy) nbusy++;
    end
    check_int("hold_no_second_done", ndone, 0);
    check_int("hold_no_second_busy", nbusy, 0);
    check("hold_result_stable", Result, C1_PT);

    // Back-to-back: second start in the done cycle of the first
    run_op(C1_KEY, C1_CT, 1'b0, 1'b0, lat);
    check_int("b2b_first_latency", lat, 21);
    check("b2b_first_result", Result, C1_PT);
    run_op(B_KEY, B_CT, 1'b0, 1'b0, lat);
    check_int("b2b_done_spacing", lat, 21);
    check("b2b_second_result", Result, B_PT);

    // Reset in the middle of an operation
    @(posedge clk); #1;
    Key = C1_KEY; Block = C1_CT; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_done", done, 1'b0);
    check("abort_result", Result, 128'h0);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check_int("abort_no_done", ndone, 0);
    run_op(C1_KEY, C1_CT, 1'b0, 1'b0, lat);
    check_int("after_abort_latency", lat, 21);
    check("after_abort_result", Result, C1_PT);

    // start together with reset is ignored
    @(posedge clk); #1;
    Key = B_KEY; Block = B_CT; start = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check_bit("start_with_reset_busy", busy, 1'b0);
    ndone = 0; nbusy = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (busy) nbusy++;
    end
    check_int("start_with_reset_no_done", ndone, 0);
    check_int("start_with_reset_no_busy", nbusy, 0);

    // Random blocks against the encryption model, inputs scrambled in flight
    for (int i = 0; i < 8; i++) begin
      rk   = {$urandom, $urandom, $urandom, $urandom};
      rp   = {$urandom, $urandom, $urandom, $urandom};
      rc_t = aes_enc(rk, rp);
      run_op(rk, rc_t, 1'b0, 1'b1, lat);
      check_int($sformatf("rand%0d_latency", i), lat, 21);
      check($sformatf("rand%0d_result", i), Result, rp);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_decrypt.md
AES_DECRYPT -- requirements
Module: aes_decrypt

Interface
REQ-001 Parameters: none; AES-128 only, Nr = 10 fixed in the shared package.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only while busy = 0.
REQ-005 Block  input  128  ciphertext, FIPS-197 byte order (Block[127:120] = byte 0, column-major state); sampled only on the accepted start cycle.
REQ-006 Key  input  128  cipher key, same byte order; sampled only on the accepted start cycle.
REQ-007 busy  output  1  high from the cycle after an accepted start until the cycle done rises.
REQ-008 done  output  1  one-cycle pulse; Result is valid in that cycle.
REQ-009 Result  output  128  plaintext, FIPS-197 byte order; holds until the next completion.

Function
REQ-010 FSM states SHALL be IDLE, KEYEXP, INIT and ROUND; reset state SHALL be IDLE.
REQ-011 IDLE with start = 1 (edge E0): SHALL latch Block and Key, set rk[0] = Key and round counter = 1, then go to KEYEXP. IDLE with start = 0 SHALL stay in IDLE.
REQ-012 KEYEXP, edges E1..E10: one FIPS-197 key-expansion step per cycle, rk[n] from rk[n-1] (RotWord, SubWord, Rcon[n]). Round keys SHALL be stored in an 11 x 128-bit register array. After rk[10] is written, the FSM SHALL go to INIT.
REQ-013 INIT, edge E11: state <= latched Block XOR rk[10]; round index = 9; go to ROUND.
REQ-014 ROUND, edges E12..E20 (index 9..1): state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR rk[index]); index decrements by 1.
REQ-015 ROUND, edge E21 (index 0): Result <= InvSubBytes(InvShiftRows(state)) XOR rk[0], with no InvMixColumns; done <= 1; go to IDLE.
REQ-016 Latency SHALL be exactly 21 cycles from the start-sampling edge to done = 1. Throughput: one block per 21 cycles.
REQ-017 start while busy = 1 SHALL be ignored; it SHALL not be queued and SHALL not disturb the operation in flight.
REQ-018 start high in the cycle where done = 1 SHALL be accepted, so back-to-back operations have no dead cycle.
REQ-019 done SHALL fall to 0 on the edge after it rises, unconditionally.
REQ-020 Changes on Block or Key after the accepted start SHALL not affect the current Result.
REQ-021 InvMixColumns SHALL use GF(2^8) multiply by 0x0e/0x0b/0x0d/0x09, reduction polynomial 0x11b.

Reset
REQ-022 reset = 1 at any edge SHALL force: state IDLE, busy = 0, done = 0, Result = 0, round counter = 0, round-key array = 0.
REQ-023 reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow for the aborted block.
REQ-024 start asserted together with reset SHALL be ignored.

Structure
REQ-025 Shared package aes_pkg SHALL hold: Nr = 10; the Rcon table; the forward S-box and inverse S-box lookup functions; GF(2^8) xtime/multiply helpers; the FSM state type.
REQ-026 One combinational sub-module aes_inv_round SHALL implement InvShiftRows -> InvSubBytes -> AddRoundKey -> optional InvMixColumns, selected by a final-round input. It SHALL be instantiated once and reused every round.
REQ-027 Key expansion SHALL reuse the forward S-box from aes_pkg; no second S-box copy.

Verification
REQ-028 FIPS-197 C.1: Key = 000102030405060708090a0b0c0d0e0f, Block = 69c4e0d86a7b0430d8cdb78070b4c55a, one start pulse -> done exactly 21 cycles later, Result = 00112233445566778899aabbccddeeff.
REQ-029 FIPS-197 App. B: Key = 2b7e151628aed2a6abf7158809cf4f3c, Block = 3925841d02dc09fbdc118597196a0b32 -> Result = 3243f6a8885a308d313198a2e0370734; rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-030 Run the C.1 vector, then hold start high through busy while toggling Block/Key -> exactly one done, Result still C.1 plaintext, no second operation until start is resampled in the done cycle.
REQ-031 Back-to-back: C.1 vector, then App. B vector with start in the done cycle -> two done pulses 21 cycles apart, correct Results.
REQ-032 Reset at cycle 10 of an operation -> busy = 0, done = 0 and Result = 0 on the next cycle; no done within 30 cycles. A fresh C.1 start afterwards -> correct Result.
REQ-033 All-zero Key and Block -> Result = 140f0f1011b5223d79587717ffd9ec3a (AES-128 D(0,0)); Result stable between done pulses.
